// File: rtl/dc_mem_ctrl_pkg.sv
// Shared definitions for the data-cache memory controller: FSM encoding,
// default geometry, command field widths and line alignment.
package dc_mem_ctrl_pkg;

   localparam int ADDR_W        = 32;
   localparam int DATA_W        = 32;
   localparam int LEN_W         = 8;
   localparam int WB_ENTRY_W    = ADDR_W + DATA_W;
   localparam int DEF_WB_DEPTH  = 4;
   localparam int DEF_BURST_LEN = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WCMD  = 2'd1,
      ST_RCMD  = 2'd2,
      ST_RDATA = 2'd3
   } dc_state_e;

   // Debug view of internal state; counters are zero-extended to 8 bits.
   typedef struct packed {
      dc_state_e  state;
      logic [7:0] wb_count;
      logic [7:0] beat_cnt;
      logic       rd_pend;
      logic       busy;
   } dc_dbg_t;

   // Clears the byte offset within a refill line of burst_len words.
   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr,
                                                    input int burst_len);
      logic [ADDR_W-1:0] mask;
      mask = ADDR_W'(burst_len * 4) - ADDR_W'(1);
      return addr & ~mask;
   endfunction

endpackage

// File: rtl/dc_mem_ctrl_if.sv
// Cache-side and memory-side signal bundle of the memory controller.
// Memory command channel: the controller raises io_mem_cmd_valid with all
// command fields and keeps them unchanged until a rising edge where
// io_mem_cmd_ready is also 1; that edge is the single transfer point.
interface dc_mem_ctrl_if;
   import dc_mem_ctrl_pkg::*;

   // cache write-through path
   logic              io_wr_req;
   logic [ADDR_W-1:0] io_wr_addr;
   logic [DATA_W-1:0] io_wr_data;
   logic              io_wr_full;
   // cache refill path
   logic              io_rd_req;
   logic [ADDR_W-1:0] io_rd_addr;
   logic              io_rd_valid;
   logic [DATA_W-1:0] io_rd_data;
   logic              io_rd_last;
   logic              io_busy;
   // memory command channel
   logic              io_mem_cmd_valid;
   logic              io_mem_cmd_ready;
   logic              io_mem_cmd_wr;
   logic [ADDR_W-1:0] io_mem_cmd_addr;
   logic [DATA_W-1:0] io_mem_cmd_wdata;
   logic [LEN_W-1:0]  io_mem_cmd_len;
   // memory read beats
   logic              io_mem_rvalid;
   logic [DATA_W-1:0] io_mem_rdata;

   // controller view
   modport slave (
      input  io_wr_req, io_wr_addr, io_wr_data, io_rd_req, io_rd_addr,
             io_mem_cmd_ready, io_mem_rvalid, io_mem_rdata,
      output io_wr_full, io_rd_valid, io_rd_data, io_rd_last, io_busy,
             io_mem_cmd_valid, io_mem_cmd_wr, io_mem_cmd_addr,
             io_mem_cmd_wdata, io_mem_cmd_len
   );

   // cache + memory view
   modport master (
      output io_wr_req, io_wr_addr, io_wr_data, io_rd_req, io_rd_addr,
             io_mem_cmd_ready, io_mem_rvalid, io_mem_rdata,
      input  io_wr_full, io_rd_valid, io_rd_data, io_rd_last, io_busy,
             io_mem_cmd_valid, io_mem_cmd_wr, io_mem_cmd_addr,
             io_mem_cmd_wdata, io_mem_cmd_len
   );

endinterface

// File: rtl/dc_wr_fifo.sv
// Synchronous write buffer: DEPTH entries of {addr,data}. Flags come from
// the registered count, so a pop in the same cycle never frees room for a
// push into a full buffer.
module dc_wr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (!do_push && do_pop) count <= count - CNT_W'(1);
      end
   end

   // Storage is only meaningful between the pointers, so it needs no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/dc_mem_ctrl.sv
// Data-cache memory controller: buffers write-through words, drains them as
// single-word write commands, and serves one line refill at a time as a
// burst read. Buffered writes always reach memory before a refill command.
module dc_mem_ctrl
   import dc_mem_ctrl_pkg::*;
#(
   parameter int WB_DEPTH  = DEF_WB_DEPTH,
   parameter int BURST_LEN = DEF_BURST_LEN
) (
   input  logic         clk,
   input  logic         reset,
   dc_mem_ctrl_if.slave bus,
   output dc_dbg_t      dbg
);

   localparam int CNT_W    = $clog2(BURST_LEN) + 1;
   localparam int WB_CNT_W = $clog2(WB_DEPTH) + 1;

   dc_state_e         state;
   logic [CNT_W-1:0]  beat_cnt;
   logic              rd_pend;
   logic              busy;
   logic [ADDR_W-1:0] line_addr;

   logic              cmd_valid;
   logic              cmd_wr;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic [LEN_W-1:0]  cmd_len;
   logic              rd_valid;
   logic              rd_last;
   logic [DATA_W-1:0] rd_data;

   logic [WB_ENTRY_W-1:0] fifo_head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [WB_CNT_W-1:0]   fifo_count;
   logic                  fifo_pop;
   logic                  rd_accept;

   // A write command leaves the buffer on the edge memory accepts it.
   assign fifo_pop  = (state == ST_WCMD) && bus.io_mem_cmd_ready;
   assign rd_accept = bus.io_rd_req && !busy;

   dc_wr_fifo #(
      .DEPTH (WB_DEPTH),
      .WIDTH (WB_ENTRY_W)
   ) u_wr_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (bus.io_wr_req),
      .push_data ({bus.io_wr_addr, bus.io_wr_data}),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Main sequencer: refill bookkeeping, command issue and beat return.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         beat_cnt  <= '0;
         rd_pend   <= 1'b0;
         busy      <= 1'b0;
         line_addr <= '0;
         cmd_valid <= 1'b0;
         cmd_wr    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         cmd_len   <= '0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         rd_data   <= '0;
      end else begin
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         rd_data  <= '0;

         // busy stays up through the cycle that presents the last word
         if (rd_accept) begin
            busy      <= 1'b1;
            rd_pend   <= 1'b1;
            line_addr <= line_align(bus.io_rd_addr, BURST_LEN);
         end else if (rd_last) begin
            busy <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state     <= ST_WCMD;
                  cmd_valid <= 1'b1;
                  cmd_wr    <= 1'b1;
                  cmd_len   <= LEN_W'(1);
                  cmd_addr  <= fifo_head[WB_ENTRY_W-1:DATA_W];
                  cmd_wdata <= fifo_head[DATA_W-1:0];
               end else if (rd_pend) begin
                  state     <= ST_RCMD;
                  cmd_valid <= 1'b1;
                  cmd_wr    <= 1'b0;
                  cmd_len   <= LEN_W'(BURST_LEN);
                  cmd_addr  <= line_addr;
                  cmd_wdata <= '0;
               end
            end
            ST_WCMD: begin
               if (bus.io_mem_cmd_ready) begin
                  state     <= ST_IDLE;
                  cmd_valid <= 1'b0;
                  cmd_wr    <= 1'b0;
                  cmd_len   <= '0;
                  cmd_addr  <= '0;
                  cmd_wdata <= '0;
               end
            end
            ST_RCMD: begin
               if (bus.io_mem_cmd_ready) begin
                  state     <= ST_RDATA;
                  rd_pend   <= 1'b0;
                  beat_cnt  <= CNT_W'(BURST_LEN);
                  cmd_valid <= 1'b0;
                  cmd_len   <= '0;
                  cmd_addr  <= '0;
               end
            end
            ST_RDATA: begin
               if (bus.io_mem_rvalid) begin
                  rd_valid <= 1'b1;
                  rd_data  <= bus.io_mem_rdata;
                  beat_cnt <= beat_cnt - CNT_W'(1);
                  if (beat_cnt == CNT_W'(1)) begin
                     rd_last <= 1'b1;
                     state   <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.io_wr_full       = fifo_full;
   assign bus.io_busy          = busy;
   assign bus.io_rd_valid      = rd_valid;
   assign bus.io_rd_data       = rd_data;
   assign bus.io_rd_last       = rd_last;
   assign bus.io_mem_cmd_valid = cmd_valid;
   assign bus.io_mem_cmd_wr    = cmd_wr;
   assign bus.io_mem_cmd_addr  = cmd_addr;
   assign bus.io_mem_cmd_wdata = cmd_wdata;
   assign bus.io_mem_cmd_len   = cmd_len;

   assign dbg = '{state:    state,
                  wb_count: 8'(fifo_count),
                  beat_cnt: 8'(beat_cnt),
                  rd_pend:  rd_pend,
                  busy:     busy};

endmodule

// File: tb/tb_dc_mem_ctrl.sv
// Directed bench for dc_mem_ctrl: write buffering, full handling, write-
// before-refill ordering, burst return, async reset abort and ignored inputs.
module tb_dc_mem_ctrl;
   import dc_mem_ctrl_pkg::*;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [7:0]  len;
   } cmd_t;

   logic    clk = 1'b0;
   logic    reset;
   dc_dbg_t dbg;
   int      checks = 0;
   int      errors = 0;
   cmd_t    got_q[$];

   dc_mem_ctrl_if bus();

   dc_mem_ctrl #(
      .WB_DEPTH  (4),
      .BURST_LEN (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .dbg   (dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // record every command transfer
   always @(posedge clk) begin
      if (reset && bus.io_mem_cmd_valid && bus.io_mem_cmd_ready)
         got_q.push_back('{bus.io_mem_cmd_wr, bus.io_mem_cmd_addr,
                           bus.io_mem_cmd_wdata, bus.io_mem_cmd_len});
   end

   // driver tasks
   task automatic idle_inputs();
      bus.io_wr_req        = 1'b0;
      bus.io_wr_addr       = '0;
      bus.io_wr_data       = '0;
      bus.io_rd_req        = 1'b0;
      bus.io_rd_addr       = '0;
      bus.io_mem_cmd_ready = 1'b0;
      bus.io_mem_rvalid    = 1'b0;
      bus.io_mem_rdata     = '0;
   endtask

   task automatic drive_write(input logic [31:0] a, input logic [31:0] d);
      bus.io_wr_req  = 1'b1;
      bus.io_wr_addr = a;
      bus.io_wr_data = d;
   endtask

   task automatic wait_cmds(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (got_q.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (got_q.size() < n) begin
         errors++;
         $display("FAIL %s_timeout: got %0d commands, required %0d", name, got_q.size(), n);
      end
   endtask

   task automatic test_reset();
      logic [135:0] outs;
      idle_inputs();
      reset = 1'b0;
      #3;
      outs = {bus.io_wr_full, bus.io_busy, bus.io_mem_cmd_valid, bus.io_mem_cmd_wr,
              bus.io_mem_cmd_addr, bus.io_mem_cmd_wdata, bus.io_mem_cmd_len,
              bus.io_rd_valid, bus.io_rd_last, bus.io_rd_data};
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", outs); end
      checks++;
      if (dbg.state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg.state, ST_IDLE); end
      checks++;
      if (dbg.wb_count !== 8'd0) begin errors++; $display("FAIL reset_wb_count: got %0d want 0", dbg.wb_count); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_write();
      cmd_t exp;
      got_q.delete();
      bus.io_mem_cmd_ready = 1'b1;
      drive_write(32'h100, 32'hDEADBEEF);
      @(negedge clk);
      bus.io_wr_req = 1'b0;
      wait_cmds(1, 20, "single_write");
      exp = '{1'b1, 32'h100, 32'hDEADBEEF, 8'd1};
      if (got_q.size() > 0) begin
         checks++;
         if (got_q[0] !== exp) begin errors++; $display("FAIL single_write_cmd: got %h want %h", got_q[0], exp); end
      end
      repeat (4) @(negedge clk);
      checks++;
      if (got_q.size() !== 1) begin errors++; $display("FAIL single_write_count: got %0d want 1", got_q.size()); end
      checks++;
      if (dbg.wb_count !== 8'd0) begin errors++; $display("FAIL single_write_empty: got %0d want 0", dbg.wb_count); end
   endtask

   task automatic test_fill_full();
      cmd_t exp;
      got_q.delete();
      bus.io_mem_cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 3) begin
            checks++;
            if (bus.io_wr_full !== 1'b0) begin errors++; $display("FAIL full_after_3: got %0b want 0", bus.io_wr_full); end
         end
         if (i == 4) begin
            checks++;
            if (bus.io_wr_full !== 1'b1) begin errors++; $display("FAIL full_after_4: got %0b want 1", bus.io_wr_full); end
         end
         drive_write(32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
         @(negedge clk);
      end
      bus.io_wr_req = 1'b0;
      checks++;
      if (dbg.wb_count !== 8'd4) begin errors++; $display("FAIL full_count: got %0d want 4", dbg.wb_count); end
      // stalled command must hold its fields
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({bus.io_mem_cmd_valid, bus.io_mem_cmd_addr, bus.io_mem_cmd_wdata} !== {1'b1, 32'h200, 32'h1000}) begin
            errors++;
            $display("FAIL cmd_hold: got %0b/%h/%h want 1/00000200/00001000",
                     bus.io_mem_cmd_valid, bus.io_mem_cmd_addr, bus.io_mem_cmd_wdata);
         end
         @(negedge clk);
      end
      // pop and push on the same edge while full: the push is dropped
      bus.io_mem_cmd_ready = 1'b1;
      drive_write(32'h2F0, 32'h2F);
      @(negedge clk);
      bus.io_wr_req = 1'b0;
      wait_cmds(4, 40, "fill_full");
      repeat (6) @(negedge clk);
      checks++;
      if (got_q.size() !== 4) begin errors++; $display("FAIL full_drop_count: got %0d want 4", got_q.size()); end
      for (int i = 0; i < 4; i++) begin
         if (got_q.size() > i) begin
            exp = '{1'b1, 32'h200 + 32'(4 * i), 32'h1000 + 32'(i), 8'd1};
            checks++;
            if (got_q[i] !== exp) begin errors++; $display("FAIL full_order_%0d: got %h want %h", i, got_q[i], exp); end
         end
      end
      checks++;
      if (bus.io_wr_full !== 1'b0) begin errors++; $display("FAIL full_cleared: got %0b want 0", bus.io_wr_full); end
   endtask

   task automatic test_refill_order();
      cmd_t exp [3];
      got_q.delete();
      bus.io_mem_cmd_ready = 1'b0;
      drive_write(32'h300, 32'h11);
      @(negedge clk);
      drive_write(32'h304, 32'h22);
      @(negedge clk);
      bus.io_wr_req = 1'b0;
      checks++;
      if (bus.io_busy !== 1'b0) begin errors++; $display("FAIL refill_busy_before: got %0b want 0", bus.io_busy); end
      bus.io_rd_req  = 1'b1;
      bus.io_rd_addr = 32'h1234;
      @(negedge clk);
      bus.io_rd_req = 1'b0;
      checks++;
      if (bus.io_busy !== 1'b1) begin errors++; $display("FAIL refill_busy_after: got %0b want 1", bus.io_busy); end
      bus.io_mem_cmd_ready = 1'b1;
      wait_cmds(3, 40, "refill_order");
      bus.io_mem_cmd_ready = 1'b0;
      exp[0] = '{1'b1, 32'h300, 32'h11, 8'd1};
      exp[1] = '{1'b1, 32'h304, 32'h22, 8'd1};
      exp[2] = '{1'b0, 32'h1230, 32'h0, 8'd4};
      for (int i = 0; i < 3; i++) begin
         if (got_q.size() > i) begin
            checks++;
            if (got_q[i] !== exp[i]) begin errors++; $display("FAIL refill_order_%0d: got %h want %h", i, got_q[i], exp[i]); end
         end
      end
      checks++;
      if (dbg.state !== ST_RDATA) begin errors++; $display("FAIL refill_state: got %0d want %0d", dbg.state, ST_RDATA); end
   endtask

   // Starts in RDATA at a negedge; returns base..base+3 and checks the
   // returned words. hold_req keeps io_rd_req high during the burst.
   task automatic test_burst(input logic [31:0] base, input logic hold_req, input string name);
      for (int i = 0; i <= 4; i++) begin
         if (i == 0) begin
            checks++;
            if (bus.io_rd_valid !== 1'b0) begin errors++; $display("FAIL %s_pre_valid: got %0b want 0", name, bus.io_rd_valid); end
         end else begin
            checks++;
            if ({bus.io_rd_valid, bus.io_rd_data, bus.io_rd_last, bus.io_busy} !==
                {1'b1, base + 32'(i - 1), (i == 4), 1'b1}) begin
               errors++;
               $display("FAIL %s_beat_%0d: got valid %0b data %h last %0b busy %0b want 1 %h %0b 1",
                        name, i, bus.io_rd_valid, bus.io_rd_data, bus.io_rd_last, bus.io_busy,
                        base + 32'(i - 1), (i == 4));
            end
         end
         bus.io_mem_rvalid = (i < 4);
         bus.io_mem_rdata  = (i < 4) ? base + 32'(i) : 32'h0;
         bus.io_rd_req     = hold_req;
         bus.io_rd_addr    = 32'h5000;
         @(negedge clk);
      end
      bus.io_rd_req = 1'b0;
      checks++;
      if ({bus.io_rd_valid, bus.io_rd_last, bus.io_busy} !== 3'b000) begin
         errors++;
         $display("FAIL %s_end: got valid %0b last %0b busy %0b want 0 0 0",
                  name, bus.io_rd_valid, bus.io_rd_last, bus.io_busy);
      end
      checks++;
      if (dbg.state !== ST_IDLE) begin errors++; $display("FAIL %s_end_state: got %0d want %0d", name, dbg.state, ST_IDLE); end
   endtask

   task automatic test_rvalid_idle();
      for (int i = 0; i < 3; i++) begin
         bus.io_mem_rvalid = 1'b1;
         bus.io_mem_rdata  = 32'h55 + 32'(i);
         @(negedge clk);
         checks++;
         if ({bus.io_rd_valid, bus.io_busy, dbg.state, dbg.beat_cnt} !== {1'b0, 1'b0, ST_IDLE, 8'd0}) begin
            errors++;
            $display("FAIL rvalid_idle_%0d: got valid %0b busy %0b state %0d cnt %0d want 0 0 0 0",
                     i, bus.io_rd_valid, bus.io_busy, dbg.state, dbg.beat_cnt);
         end
      end
      bus.io_mem_rvalid = 1'b0;
   endtask

   task automatic start_refill(input logic [31:0] a, input logic [31:0] line, input string name);
      cmd_t exp;
      got_q.delete();
      bus.io_rd_req  = 1'b1;
      bus.io_rd_addr = a;
      @(negedge clk);
      bus.io_rd_req        = 1'b0;
      bus.io_mem_cmd_ready = 1'b1;
      wait_cmds(1, 20, name);
      bus.io_mem_cmd_ready = 1'b0;
      exp = '{1'b0, line, 32'h0, 8'd4};
      if (got_q.size() > 0) begin
         checks++;
         if (got_q[0] !== exp) begin errors++; $display("FAIL %s_cmd: got %h want %h", name, got_q[0], exp); end
      end
   endtask

   task automatic test_rd_req_in_rdata();
      start_refill(32'h2008, 32'h2000, "rdreq_rdata");
      test_burst(32'h21, 1'b1, "rdreq_burst");
      repeat (8) @(negedge clk);
      checks++;
      if (got_q.size() !== 1) begin errors++; $display("FAIL rdreq_ignored: got %0d commands want 1", got_q.size()); end
      checks++;
      if (bus.io_busy !== 1'b0) begin errors++; $display("FAIL rdreq_busy: got %0b want 0", bus.io_busy); end
   endtask

   task automatic test_reset_mid_burst();
      logic [135:0] outs;
      start_refill(32'h3004, 32'h3000, "abort");
      bus.io_mem_rvalid = 1'b1;
      bus.io_mem_rdata  = 32'h31;
      @(negedge clk);
      bus.io_mem_rdata  = 32'h32;
      @(negedge clk);
      checks++;
      if (bus.io_rd_data !== 32'h32) begin errors++; $display("FAIL abort_second_beat: got %h want 00000032", bus.io_rd_data); end
      reset = 1'b0;
      bus.io_mem_rdata = 32'h33;
      #1;
      outs = {bus.io_wr_full, bus.io_busy, bus.io_mem_cmd_valid, bus.io_mem_cmd_wr,
              bus.io_mem_cmd_addr, bus.io_mem_cmd_wdata, bus.io_mem_cmd_len,
              bus.io_rd_valid, bus.io_rd_last, bus.io_rd_data};
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL abort_outputs: got %h want 0", outs); end
      checks++;
      if ({dbg.state, dbg.beat_cnt, dbg.rd_pend} !== {ST_IDLE, 8'd0, 1'b0}) begin
         errors++;
         $display("FAIL abort_state: got state %0d cnt %0d pend %0b want 0 0 0", dbg.state, dbg.beat_cnt, dbg.rd_pend);
      end
      @(negedge clk);
      reset = 1'b1;
      bus.io_mem_rdata = 32'h34;
      @(negedge clk);
      bus.io_mem_rvalid = 1'b0;
      checks++;
      if ({bus.io_rd_valid, bus.io_busy, dbg.state} !== {1'b0, 1'b0, ST_IDLE}) begin
         errors++;
         $display("FAIL abort_beats_ignored: got valid %0b busy %0b state %0d want 0 0 0",
                  bus.io_rd_valid, bus.io_busy, dbg.state);
      end
      start_refill(32'h404C, 32'h4040, "after_abort");
      test_burst(32'h40, 1'b0, "after_abort_burst");
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_fill_full();
      test_refill_order();
      test_burst(32'hA, 1'b0, "burst");
      test_rvalid_idle();
      test_rd_req_in_rdata();
      test_reset_mid_burst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dc_mem_ctrl.md
DC_MEM_CTRL -- requirements
Module: dc_mem_ctrl

Interface
REQ-001 Parameter WB_DEPTH, default 4, write-buffer entries (power of two, >=2).
REQ-002 Parameter BURST_LEN, default 4, words per refill burst (power of two, >=2).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; state clears immediately while reset=0.
REQ-005 io_wr_req  in  1  cache write-through request, one word.
REQ-006 io_wr_addr  in  32  byte address of write; io_wr_data  in  32  write word.
REQ-007 io_wr_full  out  1  write buffer holds WB_DEPTH entries.
REQ-008 io_rd_req  in  1  cache miss refill request; io_rd_addr  in  32  miss byte address.
REQ-009 io_rd_valid  out  1  refill word valid; io_rd_data  out  32  refill word; io_rd_last  out  1  final refill word.
REQ-010 io_busy  out  1  refill accepted and not yet completed.
REQ-011 io_mem_cmd_valid  out  1; io_mem_cmd_ready  in  1; io_mem_cmd_wr  out  1 (1=write); io_mem_cmd_addr  out  32; io_mem_cmd_wdata  out  32; io_mem_cmd_len  out  8 (words).
REQ-012 io_mem_rvalid  in  1; io_mem_rdata  in  32  memory read beats, one word per cycle, in order.

Function
REQ-013 Write enqueue: io_wr_req=1 and io_wr_full=0 at edge stores {addr,data} at FIFO tail; io_wr_req while full is dropped (cache stalls).
REQ-014 io_wr_full from registered count only; dequeue in same cycle does not permit enqueue when full.
REQ-015 Refill accept: io_rd_req=1 and io_busy=0 latches line address = io_rd_addr with low log2(BURST_LEN)+2 bits zeroed; io_busy=1 from next cycle.
REQ-016 io_rd_req while io_busy=1 is ignored.
REQ-017 FSM states IDLE, WCMD, RCMD, RDATA.
REQ-018 IDLE: FIFO non-empty -> WCMD; else refill pending -> RCMD; else stay.
REQ-019 WCMD: cmd_valid=1, cmd_wr=1, len=1, addr/wdata = FIFO head; on cmd_ready pop head, -> IDLE.
REQ-020 Ordering: refill command never issued while FIFO non-empty (all prior writes drained first, read-after-write safe).
REQ-021 RCMD: cmd_valid=1, cmd_wr=0, len=BURST_LEN, addr = line address, wdata=0; on cmd_ready load beat counter=BURST_LEN, -> RDATA.
REQ-022 cmd_valid, once asserted, holds with stable fields until cmd_ready.
REQ-023 RDATA: each io_mem_rvalid decrements counter; io_rd_valid/io_rd_data registered, one cycle after beat; io_rd_last with final beat's word.
REQ-024 After final beat -> IDLE; io_busy drops in the cycle io_rd_last=1 is presented ends (low next cycle).
REQ-025 io_mem_rvalid outside RDATA ignored; counter width log2(BURST_LEN)+1, no wrap.
REQ-026 Writes enqueued during RCMD/RDATA are held and drained after refill completes.
REQ-027 FIFO pointers wrap modulo WB_DEPTH; count 0..WB_DEPTH.

Reset
REQ-028 reset=0: FSM IDLE, FIFO empty, counter 0, refill flag 0; all outputs 0 (io_wr_full=0, io_busy=0, cmd_valid=0, rd_valid=0, rd_last=0, data 0).
REQ-029 Reset mid-burst or mid-command abandons the transaction; remaining rvalid beats after release are ignored.

Structure
REQ-030 Shared package holds FSM state encoding, default WB_DEPTH/BURST_LEN and cmd field widths.
REQ-031 One sub-module: dc_wr_fifo (parameterised depth x 64-bit sync FIFO with full/empty/count).

Verification
REQ-032 Single write 0x100/0xDEADBEEF, cmd_ready=1 -> one cmd wr=1 addr 0x100 wdata 0xDEADBEEF len 1, FIFO empty after.
REQ-033 Five back-to-back writes, cmd_ready=0 -> io_wr_full=1 after 4th, 5th dropped; release ready -> exactly 4 write cmds in order.
REQ-034 Refill addr 0x1234 with 2 writes queued -> 2 write cmds then read cmd addr 0x1230 len 4.
REQ-035 Memory returns 0xA,0xB,0xC,0xD on consecutive rvalid -> rd_valid 4 cycles, data in order one cycle late, rd_last only with 0xD, io_busy low next cycle.
REQ-036 Assert reset low after 2nd beat -> outputs 0 immediately; remaining beats ignored; new refill accepted normally.
REQ-037 io_rd_req during RDATA and rvalid in IDLE -> no effect on state or outputs.
